uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
//
// PURPOSE
//   UART transmitter. Serializes one SIZE-bit parallel word per request onto a single tx line.
//   Frame: start bit (0), SIZE data bits LSB first, optional parity bit, one stop bit (1).
//   Sits between the host-side byte source and the pad; the driver watches tx_busy.
//   The frame monitor samples tx at bit-centre.
//
// PARAMETERS
//   SIZE          8   data bits per frame (1..16)
//   CLKS_PER_BIT  16  clk cycles per serial bit (>=2); sets the baud rate (clk/CLKS_PER_BIT)
//
// PORTS
//   clk      in   1     system clock; all logic on rising edge
//   rst      in   1     synchronous, active-high reset
//   data_in  in   SIZE  word to send; sampled only on the accept edge
//   tx_en    in   1     transmit request, level-sampled each edge
//   tx       out  1     serial line, idle high; registered
//   tx_busy  out  1     high while a frame is in flight; registered
//
// BEHAVIOUR
//   - One clock, clk. Reset rst is synchronous and active-high.
//     * Reset state: FSM=IDLE, tx=1, tx_busy=0, bit counter=0, baud counter=0, shift reg=0.
//     * Reset mid-frame aborts the frame at that edge: tx=1, tx_busy=0 after the edge.
//     * rst dominates tx_en.
//   - FSM states and transitions:
//     * IDLE -> START: on an edge with tx_en=1 and tx_busy=0.
//     * START -> DATA -> [PARITY] -> STOP -> IDLE.
//   - Accept edge (IDLE, tx_en=1):
//     * data_in is latched into the shift register.
//     * After that edge: tx=0, tx_busy=1. There is no extra latency cycle.
//   - Bit timing:
//     * Each bit, including start and stop, holds tx constant for exactly CLKS_PER_BIT cycles.
//     * The baud counter runs 0..CLKS_PER_BIT-1, then the next bit is driven.
//   - DATA state: sends shift-reg bit 0 first, shifts right, SIZE bits total; counter wraps at SIZE-1.
//   - STOP state:
//     * tx=1 for CLKS_PER_BIT cycles.
//     * At the edge ending the stop bit: FSM=IDLE, tx_busy=0, tx stays 1.
//   - Frame length, edge to edge: (SIZE+2)*CLKS_PER_BIT cycles, plus CLKS_PER_BIT if parity is enabled.
//   - Request handling:
//     * tx_en while tx_busy=1 is ignored; there is no queueing.
//     * data_in changes mid-frame have no effect.
//   - Back-to-back (tx_en held high):
//     * tx_busy drops for exactly one cycle, then the next frame is accepted.
//     * The line sees stop bit + 1 idle clk between frames.
//   - tx never glitches: a registered output changes only at bit boundaries.
//
// CONFIGURATION
//   UART_TX_PARITY_EN defined:
//     * A PARITY state sits between DATA and STOP.
//     * It sends the even-parity bit (XOR of the latched word) for CLKS_PER_BIT cycles.
//   UART_TX_PARITY_EN undefined:
//     * No PARITY state and no parity logic; DATA goes straight to STOP.
//
// TESTING  (SIZE=8, CLKS_PER_BIT=16, clk period 1000)
//   1. Hold rst=1 for 1 clk, release.
//      -> tx=1, tx_busy=0.
//      -> No activity with tx_en=0 for 100 clks.
//   2. data_in=8'hA5, tx_en pulse for 1 clk.
//      -> Bit-centre samples of tx: 0,1,0,1,0,0,1,0,1,1 (parity adds a 0 before stop).
//      -> tx_busy high for 160 clks (176 with parity).
//   3. Pulse tx_en with 8'h3C, then pulse again with 8'hFF at clk 40.
//      -> Only 8'h3C is transmitted.
//      -> The second request is dropped; tx_busy never falls mid-frame.
//   4. Hold tx_en=1; data_in=8'h00, then 8'hFF after the first accept.
//      -> Two frames.
//      -> tx_busy low for exactly 1 clk between them; tx high 17 clks between the last data bit and the next start.
//   5. Start 8'h55; assert rst at clk 70 (mid-data).
//      -> tx=1, tx_busy=0 after that edge.
//      -> A new 8'h81 frame after release transmits correctly.
//   6. data_in changed on every clk during a frame.
//      -> The serialized word equals the value latched on the accept edge.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// UART transmitter: start bit, SIZE data bits LSB first, optional even parity, one stop bit.
// Define UART_TX_PARITY_EN to insert the even-parity bit between the data and stop bits.
//
// state    | meaning
// ---------+----------------------------------------------------
// S_IDLE   | line high, waiting for tx_en
// S_START  | driving the start bit (0)
// S_DATA   | driving shift-register bit 0, SIZE bits in total
// S_PARITY | driving the even-parity bit (parity build only)
// S_STOP   | driving the stop bit (1); returns to S_IDLE
module uart_tx_serializer #(
  parameter int SIZE         = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] data_in,
  input  logic            tx_en,
  output logic            tx,
  output logic            tx_busy
);

  localparam int BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int BIT_W  = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(SIZE - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t            state;
  logic [BAUD_W-1:0] baud_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [SIZE-1:0]   shreg;
`ifdef UART_TX_PARITY_EN
  logic              parity_bit;
`endif

  wire baud_done = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (tx_en) begin
            state    <= S_START;
            tx       <= 1'b0;
            tx_busy  <= 1'b1;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shreg    <= data_in;
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^data_in;
`endif
          end
        end
        S_START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= S_DATA;
            tx       <= shreg[0];
            shreg    <= shreg >> 1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
              state <= S_PARITY;
              tx    <= parity_bit;
`else
              state <= S_STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= S_STOP;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
`endif
        S_STOP: begin
          // tx is already high; only the busy flag and state change here
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= S_IDLE;
            tx_busy  <= 1'b0;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          tx       <= 1'b1;
          tx_busy  <= 1'b0;
          baud_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Scoreboard bench for uart_tx_serializer: stimulus queues expected frames, a line monitor
// samples tx at bit centres and compares against the queue.
module tb_uart_tx_serializer;

  localparam int SIZE = 8;
  localparam int CPB  = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = SIZE + 3;
`else
  localparam int NB = SIZE + 2;
`endif
  localparam int FRAME_CLKS = NB * CPB;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [SIZE-1:0] data_in = '0;
  logic            tx_en = 1'b0;
  logic            tx;
  logic            tx_busy;

  int total = 0;
  int bad   = 0;
  int rst_pulses = 0;
  logic [NB-1:0] exp_q[$];

  uart_tx_serializer #(.SIZE(SIZE), .CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .tx_en(tx_en), .tx(tx), .tx_busy(tx_busy)
  );

  always #500 clk = ~clk;

  function automatic logic [NB-1:0] frame_of(input logic [SIZE-1:0] d);
`ifdef UART_TX_PARITY_EN
    return {1'b1, ^d, d, 1'b0};
`else
    return {1'b1, d, 1'b0};
`endif
  endfunction

  task automatic check(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // issue a one-clock tx_en pulse; returns at the negedge after the accept edge
  task automatic pulse(input logic [SIZE-1:0] d);
    @(negedge clk);
    data_in = d;
    tx_en   = 1'b1;
    @(negedge clk);
    tx_en   = 1'b0;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (tx_busy === 1'b1 && n < 400) begin
      n++;
      @(negedge clk);
    end
  endtask

  // line monitor: a low on an idle line marks a start bit
  initial begin
    logic [NB-1:0] frame;
    logic [NB-1:0] exp;
    int rp;
    bit aborted;
    forever begin
      @(negedge clk);
      if (tx === 1'b0 && rst === 1'b0) begin
        rp = rst_pulses;
        aborted = 1'b0;
        frame = '0;
        for (int b = 0; b < NB; b++) begin
          repeat ((b == 0) ? (CPB/2 - 1) : CPB) @(negedge clk);
          if (rst_pulses != rp) begin
            aborted = 1'b1;
            break;
          end
          frame[b] = tx;
        end
        if (!aborted) begin
          total++;
          if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL frame_unexpected: got %b expected no frame", frame);
          end else begin
            exp = exp_q.pop_front();
            if (frame !== exp) begin
              bad++;
              $display("FAIL frame: got %b expected %b", frame, exp);
            end
          end
        end
      end
    end
  end

  initial begin
    int n, gap, run, quiet;

    // 1: reset and quiet idle
    @(negedge clk);
    rst = 1'b1;
    rst_pulses++;
    @(negedge clk);
    rst = 1'b0;
    check("reset_tx", int'(tx), 1);
    check("reset_busy", int'(tx_busy), 0);
    quiet = 1;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1 || tx_busy !== 1'b0) quiet = 0;
    end
    check("idle_quiet", quiet, 1);

    // 2: single frame A5, no accept latency
    exp_q.push_back(frame_of(8'hA5));
    pulse(8'hA5);
    check("accept_tx_low", int'(tx), 0);
    check("accept_busy", int'(tx_busy), 1);
    count_busy(n);
    check("busy_len_a5", n, FRAME_CLKS);
    repeat (20) @(negedge clk);

    // 3: second request mid-frame is dropped
    exp_q.push_back(frame_of(8'h3C));
    pulse(8'h3C);
    n = 0;
    while (tx_busy === 1'b1 && n < 400) begin
      n++;
      if (n == 39) begin data_in = 8'hFF; tx_en = 1'b1; end
      if (n == 40) tx_en = 1'b0;
      @(negedge clk);
    end
    check("busy_len_3c", n, FRAME_CLKS);
    repeat (200) @(negedge clk);

    // 4: back-to-back with tx_en held
    exp_q.push_back(frame_of(8'h00));
    exp_q.push_back(frame_of(8'hFF));
    @(negedge clk);
    data_in = 8'h00;
    tx_en   = 1'b1;
    @(negedge clk);
    data_in = 8'hFF;
    run = 0;
    n = 0;
    while (tx_busy === 1'b1 && n < 400) begin
      run = (tx === 1'b1) ? run + 1 : 0;
      n++;
      @(negedge clk);
    end
    gap = 0;
    while (tx_busy === 1'b0 && gap < 5) begin
      run = (tx === 1'b1) ? run + 1 : 0;
      gap++;
      @(negedge clk);
    end
    tx_en = 1'b0;
    check("b2b_first_len", n, FRAME_CLKS);
    check("b2b_busy_gap", gap, 1);
    check("b2b_high_run", run, CPB + 1);
    check("b2b_second_start", int'(tx), 0);
    count_busy(n);
    check("b2b_second_len", n, FRAME_CLKS);
    repeat (20) @(negedge clk);

    // 5: reset at clk 70 of a 55 frame, then 81
    pulse(8'h55);
    repeat (69) @(negedge clk);
    rst = 1'b1;
    rst_pulses++;
    @(negedge clk);
    rst = 1'b0;
    check("abort_tx", int'(tx), 1);
    check("abort_busy", int'(tx_busy), 0);
    repeat (20) @(negedge clk);
    exp_q.push_back(frame_of(8'h81));
    pulse(8'h81);
    count_busy(n);
    check("busy_len_81", n, FRAME_CLKS);
    repeat (20) @(negedge clk);

    // 6: data_in churns every clk during the frame
    exp_q.push_back(frame_of(8'hC3));
    pulse(8'hC3);
    n = 0;
    while (tx_busy === 1'b1 && n < 400) begin
      data_in = SIZE'($urandom);
      n++;
      @(negedge clk);
    end
    check("busy_len_c3", n, FRAME_CLKS);

    repeat (100) @(negedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
